// File: rtl/gen2_inv_ctrl.sv
// Gen2 tag inventory/access state controller: consumes decoded command strobes, tracks tag state,
// slot counter, RN16 and handle, and requests replies from the backscatter encoder.
module gen2_inv_ctrl #(
  parameter int unsigned T2_CYCLES = 200,
  parameter int unsigned SLOT_W    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmdok_dec,
  input  logic              i_crc_ok,
  input  logic              i_query,
  input  logic              i_queryrep,
  input  logic              i_queryadjust,
  input  logic              i_ack,
  input  logic              i_nak,
  input  logic              i_reqrn,
  input  logic              i_select,
  input  logic [3:0]        i_q_dec,
  input  logic [1:0]        i_session_dec,
  input  logic [1:0]        i_session2_dec,
  input  logic [15:0]       i_handle_dec,
  input  logic              i_sel_match,
  input  logic              i_pw_zero,
  input  logic              i_access_ok,
  input  logic [15:0]       i_rn16,
  input  logic              i_tx_done,
  output logic [2:0]        o_state,
  output logic [SLOT_W-1:0] o_slot,
  output logic [15:0]       o_rn16,
  output logic [15:0]       o_handle,
  output logic [1:0]        o_session,
  output logic              o_tx_req,
  output logic [1:0]        o_tx_type,
  output logic              o_rn_next,
  output logic              o_clear_dec,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    StReady        = 3'd0,
    StArbitrate    = 3'd1,
    StReply        = 3'd2,
    StAcknowledged = 3'd3,
    StOpen         = 3'd4,
    StSecured      = 3'd5
  } state_e;

  localparam logic [1:0] TxRn16   = 2'd0;
  localparam logic [1:0] TxEpc    = 2'd1;
  localparam logic [1:0] TxHandle = 2'd2;

  localparam int unsigned CntW = (T2_CYCLES > 1) ? $clog2(T2_CYCLES) : 1;
  localparam logic [CntW-1:0] T2Last = CntW'(T2_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [15:0]       rn16_q, rn16_d;
  logic [15:0]       handle_q, handle_d;
  logic [1:0]        session_q, session_d;
  logic              tx_req_q, tx_req_d;
  logic [1:0]        tx_type_q, tx_type_d;
  logic              rn_next_q, rn_next_d;
  logic              clear_q, clear_d;
  logic              busy_q, busy_d;
  logic [CntW-1:0]   t2_cnt_q, t2_cnt_d;

  logic              accept, proc, do_draw, t2_run, t2_hit;
  logic [SLOT_W-1:0] slot_mask, slot_draw;

  assign accept = i_cmdok_dec && !busy_q;
  assign proc   = accept && i_crc_ok;

  // Low Q bits of the RNG; shifting past SLOT_W leaves an all-ones mask.
  assign slot_mask = ~({SLOT_W{1'b1}} << i_q_dec);
  assign slot_draw = SLOT_W'(i_rn16) & slot_mask;

  assign t2_run = ((state_q == StReply) || (state_q == StAcknowledged)) && !busy_q;
  assign t2_hit = t2_run && (t2_cnt_q == T2Last);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    rn16_d    = rn16_q;
    handle_d  = handle_q;
    session_d = session_q;
    tx_req_d  = 1'b0;
    tx_type_d = TxRn16;
    rn_next_d = 1'b0;
    clear_d   = accept;
    do_draw   = 1'b0;

    if (proc) begin
      if (i_query) begin
        if (!i_sel_match) begin
          state_d = StReady;
        end else begin
          session_d = i_session_dec;
          do_draw   = 1'b1;
        end
      end else if (i_queryrep) begin
        if (i_session2_dec == session_q) begin
          case (state_q)
            StArbitrate: begin
              slot_d = slot_q - SLOT_W'(1);
              if (slot_q == SLOT_W'(1)) begin
                state_d   = StReply;
                rn16_d    = i_rn16;
                rn_next_d = 1'b1;
                tx_req_d  = 1'b1;
                tx_type_d = TxRn16;
              end
            end
            StReply, StAcknowledged, StOpen, StSecured: state_d = StArbitrate;
            default: ;
          endcase
        end
      end else if (i_queryadjust) begin
        if (i_session2_dec == session_q) begin
          case (state_q)
            StArbitrate, StReply:               do_draw = 1'b1;
            StAcknowledged, StOpen, StSecured:  state_d = StArbitrate;
            default: ;
          endcase
        end
      end else if (i_ack) begin
        case (state_q)
          StReply, StAcknowledged: begin
            if (i_handle_dec == rn16_q) begin
              tx_req_d  = 1'b1;
              tx_type_d = TxEpc;
              state_d   = StAcknowledged;
            end else begin
              state_d = StArbitrate;
            end
          end
          StOpen, StSecured: begin
            if (i_handle_dec == handle_q) begin
              tx_req_d  = 1'b1;
              tx_type_d = TxEpc;
            end else begin
              state_d = StArbitrate;
            end
          end
          default: ;
        endcase
      end else if (i_reqrn) begin
        case (state_q)
          StAcknowledged: begin
            if (i_handle_dec == rn16_q) begin
              handle_d  = i_rn16;
              rn_next_d = 1'b1;
              tx_req_d  = 1'b1;
              tx_type_d = TxHandle;
              state_d   = i_pw_zero ? StSecured : StOpen;
            end
          end
          StOpen, StSecured: begin
            if (i_handle_dec == handle_q) begin
              rn16_d    = i_rn16;
              rn_next_d = 1'b1;
              tx_req_d  = 1'b1;
              tx_type_d = TxRn16;
            end
          end
          default: ;
        endcase
      end else if (i_nak) begin
        if (state_q != StReady) state_d = StArbitrate;
      end else if (i_select) begin
        state_d = StReady;
      end
    end else if (i_access_ok && (state_q == StOpen)) begin
      state_d = StSecured;
    end else if (t2_hit && !accept) begin
      state_d = StArbitrate;
    end

    if (do_draw) begin
      slot_d    = slot_draw;
      rn_next_d = 1'b1;
      if (slot_draw == '0) begin
        state_d   = StReply;
        rn16_d    = i_rn16;
        tx_req_d  = 1'b1;
        tx_type_d = TxRn16;
      end else begin
        state_d = StArbitrate;
      end
    end

    // A new request beats a simultaneous completion of the previous one.
    if (tx_req_d)       busy_d = 1'b1;
    else if (i_tx_done) busy_d = 1'b0;
    else                busy_d = busy_q;

    if ((state_d != state_q) || accept || i_tx_done) t2_cnt_d = '0;
    else if (t2_run)                                  t2_cnt_d = t2_cnt_q + CntW'(1);
    else                                              t2_cnt_d = t2_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReady;
      slot_q    <= '0;
      rn16_q    <= '0;
      handle_q  <= '0;
      session_q <= '0;
      tx_req_q  <= 1'b0;
      tx_type_q <= TxRn16;
      rn_next_q <= 1'b0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      t2_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      rn16_q    <= rn16_d;
      handle_q  <= handle_d;
      session_q <= session_d;
      tx_req_q  <= tx_req_d;
      tx_type_q <= tx_type_d;
      rn_next_q <= rn_next_d;
      clear_q   <= clear_d;
      busy_q    <= busy_d;
      t2_cnt_q  <= t2_cnt_d;
    end
  end

  assign o_state     = state_q;
  assign o_slot      = slot_q;
  assign o_rn16      = rn16_q;
  assign o_handle    = handle_q;
  assign o_session   = session_q;
  assign o_tx_req    = tx_req_q;
  assign o_tx_type   = tx_type_q;
  assign o_rn_next   = rn_next_q;
  assign o_clear_dec = clear_q;
  assign o_busy      = busy_q;

endmodule

// File: doc/gen2_inv_ctrl.md
Name: gen2_inv_ctrl

Overview:
- Tag-side inventory/access state controller; sits directly after the command decoder.
- Consumes one decoded-command strobe per frame and tracks the Gen2 tag state (Ready/Arbitrate/Reply/Acknowledged/Open/Secured).
- Maintains the slot counter, current RN16 and handle, and issues reply requests to the backscatter encoder.
- Clears the decoder once each command has been consumed.

Parameters:
T2_CYCLES, 200, cycles without a valid command in REPLY/ACKNOWLEDGED before falling back to ARBITRATE
SLOT_W, 15, slot counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_cmdok_dec  in  1  1-cycle pulse: decoder finished a frame; command flags below valid this cycle
i_crc_ok  in  1  CRC check result, sampled with i_cmdok_dec
i_query, i_queryrep, i_queryadjust, i_ack, i_nak, i_reqrn, i_select  in  1 each  decoded command flags (at most one high)
i_q_dec  in  4  Q value (already adjusted for QueryAdjust)
i_session_dec  in  2  session field of Query
i_session2_dec  in  2  session field of QueryRep/QueryAdjust
i_handle_dec  in  16  RN16/handle field of the received command
i_sel_match  in  1  tag matches Query Sel/Target criteria
i_pw_zero  in  1  access password is zero
i_access_ok  in  1  1-cycle pulse: Access password sequence verified
i_rn16  in  16  current RNG output
i_tx_done  in  1  1-cycle pulse: encoder finished the reply
o_state  out  3  0 READY, 1 ARBITRATE, 2 REPLY, 3 ACKNOWLEDGED, 4 OPEN, 5 SECURED
o_slot  out  SLOT_W  slot counter
o_rn16  out  16  last RN16 backscattered
o_handle  out  16  current handle
o_session  out  2  session of the active inventory round
o_tx_req  out  1  1-cycle reply request
o_tx_type  out  2  0 RN16, 1 EPC, 2 HANDLE; valid with o_tx_req
o_rn_next  out  1  1-cycle pulse: RNG value consumed, advance RNG
o_clear_dec  out  1  1-cycle pulse: clear decoder command flags
o_busy  out  1  reply in flight (o_tx_req issued, i_tx_done not yet received)

Behaviour:
- Reset: state READY; slot 0; rn16 0; handle 0; session 0; all pulses 0; busy 0; timeout counter 0.
- Command accepted only when i_cmdok_dec=1 and o_busy=0.
  - Accepted with i_crc_ok=1: processed.
  - Accepted with i_crc_ok=0: no state change.
  - o_clear_dec pulses the cycle after every accepted i_cmdok_dec, CRC good or bad.
  - i_cmdok_dec while busy: ignored, no clear.
- Latency: state/slot/rn16/handle update and o_tx_req/o_rn_next are all registered, one cycle after i_cmdok_dec.
- Query (any state):
  - i_sel_match=0 -> READY, no reply.
  - Otherwise: session <= i_session_dec; slot <= i_rn16 & ((1<<Q)-1) (Q=0 gives slot 0); o_rn_next=1.
  - Slot==0 -> REPLY: rn16 <= i_rn16 sampled the same cycle, tx RN16.
  - Slot!=0 -> ARBITRATE.
- QueryRep:
  - i_session2_dec != session: ignored.
  - ARBITRATE: slot <= slot-1. Slot 0 wraps to all-ones and stays ARBITRATE. Result 0 -> REPLY: draw new rn16, o_rn_next, tx RN16.
  - REPLY/ACKNOWLEDGED/OPEN/SECURED -> ARBITRATE, slot unchanged.
  - READY: ignored.
- QueryAdjust (session match, state != READY):
  - Re-draw slot from i_rn16 with new i_q_dec, same rules as Query.
  - ACKNOWLEDGED/OPEN/SECURED -> ARBITRATE with no re-draw.
- ACK:
  - REPLY/ACKNOWLEDGED/OPEN/SECURED with i_handle_dec==rn16 (REPLY/ACK) or ==handle (OPEN/SECURED): tx EPC.
  - Match in REPLY -> ACKNOWLEDGED; match elsewhere: state unchanged.
  - Mismatch -> ARBITRATE.
- ReqRN:
  - ACKNOWLEDGED with handle match on rn16: handle <= i_rn16, o_rn_next, tx HANDLE; -> SECURED if i_pw_zero else OPEN.
  - OPEN/SECURED with match on handle: rn16 <= i_rn16, o_rn_next, tx RN16, state unchanged.
  - Mismatch: ignored.
- NAK: any state except READY -> ARBITRATE.
- Select: any state -> READY, no reply.
- i_access_ok in OPEN -> SECURED; ignored in all other states.
- Busy: o_busy set with o_tx_req, cleared on i_tx_done. i_tx_done and o_tx_req in the same cycle: set wins.
- T2 timeout:
  - Counter runs in REPLY/ACKNOWLEDGED while not busy.
  - Cleared on state change, accepted command, or i_tx_done.
  - Reaching T2_CYCLES -> ARBITRATE.
  - Accepted i_cmdok_dec in the same cycle has priority over the timeout.
- Reset mid-operation: all registers return to reset values immediately; any pending reply is abandoned.

Test Plan:
- Query Q=0, sel_match=1, i_rn16=0xBEEF -> REPLY, o_rn16=0xBEEF, tx_req type 0 one cycle after cmdok, o_clear_dec pulsed.
- Query Q=2, i_rn16=0x0003 -> ARBITRATE slot 3; three session-matched QueryReps -> slot 2,1,0; third gives REPLY and RN16 tx. QueryRep with wrong session -> slot unchanged.
- REPLY rn16=0x1234: ACK handle 0x1234 -> ACKNOWLEDGED, EPC tx. Repeat with ACK handle 0x1235 -> ARBITRATE, no tx.
- ACKNOWLEDGED: ReqRN match, i_pw_zero=0, i_rn16=0x5A5A -> OPEN, o_handle=0x5A5A, HANDLE tx. Then i_access_ok -> SECURED. With i_pw_zero=1 the same ReqRN goes direct to SECURED.
- REPLY with no command for T2_CYCLES -> ARBITRATE. Same setup with cmdok(QueryRep) on the timeout cycle -> QueryRep result wins.
- Bad CRC Query -> state unchanged, o_clear_dec pulsed. Cmdok while o_busy=1 -> ignored, no clear. Select from SECURED -> READY. rst_n low mid-reply -> all outputs at reset values.
